do_loop_seq: RTL and testbench

Sequential, parametrised successor to the combinational do-while bit-copy cosim block. It executes one loop-body iteration per clock over N lanes and honours do-while semantics: the body always runs at least once, then continues while `i < limit`. Each iteration copies one low input bit and ANDs paired nibble lanes. It sits in the statement cosim suite as the clocked do-while case, with a start/busy/done handshake.

---
 rtl/do_loop_pkg.sv | 20 ++
 rtl/do_loop_body.sv | 15 +
 rtl/do_loop_seq.sv | 113 +++++++++++
 tb/tb_do_loop_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/do_loop_pkg.sv
// Shared types and helpers for the clocked do-while lane-copy block.
package do_loop_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } do_loop_state_e;

   // Effective iteration count: the body runs at least once and never past N lanes.
   function automatic int unsigned eff_iters(input int unsigned limit, input int unsigned n);
      if (limit == 0)
         return 1;
      else if (limit > n)
         return n;
      else
         return limit;
   endfunction

endpackage

// File: rtl/do_loop_body.sv
// One loop-body lane: copy the low operand bit and AND it with its paired bit.
module do_loop_body (
   input  logic lo_bit,
   input  logic hi_bit,
   output logic low,
   output logic high
);

   // Lane result is purely combinational.
   always_comb begin
      low  = lo_bit;
      high = lo_bit & hi_bit;
   end

endmodule

// File: rtl/do_loop_seq.sv
// Clocked do-while: one lane iteration per cycle with start/busy/done handshake.
module do_loop_seq
   import do_loop_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = 128
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [W-1:0]           in,
   input  logic [$clog2(N):0]     limit,
   output logic                   busy,
   output logic                   done,
   output logic [W-1:0]           out
);

   localparam int LW = $clog2(N) + 1;

   do_loop_state_e  state;
   logic [2*N-1:0]  in_q;
   logic [LW-1:0]   limit_q;
   logic [LW-1:0]   i;
   logic [LW-1:0]   k;
   logic [N-1:0]    low;
   logic [N-1:0]    high;
   logic            lane_lo;
   logic            lane_hi;
   logic            body_low;
   logic            body_high;

   // Operand bits above the two nibble lanes never reach the result.
   if (W > 2*N) begin : g_unused
      logic unused_in;
      assign unused_in = ^in[W-1:2*N];
   end

   assign k = LW'(eff_iters(32'(limit_q), N));

   // Select the operand pair for the current iteration; the loop compare avoids a variable-width index.
   always_comb begin
      lane_lo = 1'b0;
      lane_hi = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         if (i == LW'(j)) begin
            lane_lo = in_q[j];
            lane_hi = in_q[N+j];
         end
      end
   end

   do_loop_body u_body (
      .lo_bit (lane_lo),
      .hi_bit (lane_hi),
      .low    (body_low),
      .high   (body_high)
   );

   // Control FSM, counter, capture registers and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         out     <= '0;
         i       <= '0;
         low     <= '0;
         high    <= '0;
         in_q    <= '0;
         limit_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  in_q    <= in[2*N-1:0];
                  limit_q <= limit;
                  low     <= '0;
                  high    <= '0;
                  i       <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               for (int unsigned j = 0; j < N; j++) begin
                  if (i == LW'(j)) begin
                     low[j]  <= body_low;
                     high[j] <= body_high;
                  end
               end
               // Exit test comes after the body, giving do-while semantics.
               if ((i + LW'(1)) >= k) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  i <= i + LW'(1);
               end
            end
            DONE: begin
               done            <= 1'b0;
               busy            <= 1'b0;
               out             <= '0;
               out[2*N-1:0]    <= {high, low};
               state           <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_do_loop_seq.sv
// Directed bench for do_loop_seq at N=4/W=128 and N=8/W=16.
module tb_do_loop_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         start4;
   logic [127:0] in4;
   logic [2:0]   limit4;
   logic         busy4;
   logic         done4;
   logic [127:0] out4;
   logic         start8;
   logic [15:0]  in8;
   logic [3:0]   limit8;
   logic         busy8;
   logic         done8;
   logic [15:0]  out8;

   int checks = 0;
   int errors = 0;
   logic [127:0] last_out4 = '0;

   always #5 clk = ~clk;

   do_loop_seq #(.N(4), .W(128)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .in    (in4),
      .limit (limit4),
      .busy  (busy4),
      .done  (done4),
      .out   (out4)
   );

   do_loop_seq #(.N(8), .W(16)) u_dut8 (
      .clk   (clk),
      .rst   (rst),
      .start (start8),
      .in    (in8),
      .limit (limit8),
      .busy  (busy8),
      .done  (done8),
      .out   (out8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One complete run on the N=4 instance; poke disturbs in/start during the first RUN cycle.
   task automatic run4(input string tag, input logic [127:0] din, input logic [2:0] lim,
                       input int k, input logic [127:0] exp_out, input bit poke);
      int cyc;
      in4    = din;
      limit4 = lim;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      check({tag, ":busy_rise"}, 128'(busy4), 128'(1));
      cyc = 1;
      if (poke) begin
         in4    = '0;
         limit4 = 3'd1;
         start4 = 1'b1;
         tick();
         start4 = 1'b0;
         cyc = 2;
      end
      while (done4 !== 1'b1 && cyc < 12) begin
         tick();
         cyc++;
      end
      check({tag, ":done_cycle"}, 128'(cyc), 128'(k + 1));
      check({tag, ":out_hold"}, out4, last_out4);
      tick();
      check({tag, ":done_fall"}, 128'(done4), 128'(0));
      check({tag, ":busy_fall"}, 128'(busy4), 128'(0));
      check({tag, ":out"}, out4, exp_out);
      last_out4 = exp_out;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  cyc;
      bit  saw_done;
      rst    = 1'b1;
      start4 = 1'b0;
      in4    = '0;
      limit4 = '0;
      start8 = 1'b0;
      in8    = '0;
      limit8 = '0;
      tick();
      tick();
      check("reset:busy", 128'(busy4), 128'(0));
      check("reset:done", 128'(done4), 128'(0));
      check("reset:out", out4, 128'(0));
      check("reset:out8", 128'(out8), 128'(0));
      rst = 1'b0;
      tick();

      // Runs are issued back-to-back: each starts in the first IDLE cycle after the previous DONE.
      run4("full", 128'h3F, 3'd4, 4, 128'h3F, 1'b0);
      run4("lim2", 128'hFF, 3'd2, 2, 128'h33, 1'b0);
      run4("lim0", 128'hFF, 3'd0, 1, 128'h11, 1'b0);
      run4("lim1", 128'hA5, 3'd1, 1, 128'h01, 1'b0);
      run4("clamp", 128'hFF, 3'd7, 4, 128'hFF, 1'b0);
      run4("hi_bits", {96'hFFFF, 32'h0000_005A}, 3'd3, 3, 128'h02, 1'b0);
      run4("ignore", 128'hFF, 3'd4, 4, 128'hFF, 1'b1);

      // Reset in the second RUN cycle aborts the run.
      in4    = 128'hFF;
      limit4 = 3'd4;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort:busy", 128'(busy4), 128'(0));
      check("abort:done", 128'(done4), 128'(0));
      check("abort:out", out4, 128'(0));
      last_out4 = '0;
      saw_done = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (done4 === 1'b1) saw_done = 1'b1;
      end
      check("abort:no_done", 128'(saw_done), 128'(0));
      check("abort:idle_busy", 128'(busy4), 128'(0));

      run4("after_abort", 128'hC3, 3'd4, 4, 128'h03, 1'b0);

      // Wider instance.
      in8    = 16'hF0FF;
      limit8 = 4'd8;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      check("n8:busy_rise", 128'(busy8), 128'(1));
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("n8:done_cycle", 128'(cyc), 128'(9));
      tick();
      check("n8:out", 128'(out8), 128'(16'hF0FF));
      check("n8:busy_fall", 128'(busy8), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
